byte_packer: RTL and testbench
==============================

# byte_packer

Ingress framing stage placed directly upstream of `packet_decoder`. It accepts a byte-serial frame stream and packs it big-endian into 32-bit beats, driving exactly the `packet4_byte` / `data_valid` / `last_valid` / `keep` interface the decoder consumes. It enforces the 1522-byte MTU by truncating and discarding oversize frames, and it flags runt frames shorter than an Ethernet header.

## Interface
- `MTU_BYTES`, default 1522: maximum bytes forwarded per frame.
- `MIN_HDR_BYTES`, default 14: frames shorter than this are flagged as runts.
- `clk` in 1: single clock. Everything is synchronous to its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rx_byte` in 8: input byte.
- `rx_valid` in 1: `rx_byte` is valid this cycle.
- `rx_last` in 1: final byte of the frame; qualified by `rx_valid`.
- `packet4_byte` out 32: packed beat. The first byte of the beat is in [31:24].
- `data_valid` out 1: beat valid, one-cycle pulse per beat.
- `last_valid` out 1: final beat of the frame; qualified by `data_valid`.
- `keep` out 4: on the last beat, a thermometer code of the valid-byte count (1→0001, 2→0011, 3→0111, 4→1111). It is 1111 on every non-last beat.
- `frame_runt` out 1: pulses with the last beat when the frame has fewer than `MIN_HDR_BYTES` bytes.
- `frame_oversize` out 1: pulses with the last beat of a truncated frame.
- `stat_frames` out 32, `stat_runts` out 16, `stat_oversize` out 16: counters (see Configuration).

## Operation
- Source has no backpressure. The block never stalls and never drops a byte inside `MTU_BYTES`.
- FSM states: IDLE, PACK, DISCARD.
  - IDLE: the first valid byte starts a frame. Lane 0 is loaded, `byte_cnt` is set to 1, and the FSM moves to PACK. If that byte has `rx_last` set, the frame is a 1-byte frame: emit it immediately with keep 0001 and raise `frame_runt`.
  - PACK: each valid byte goes into lane `byte_cnt[1:0]`, filling [31:24] first, and `byte_cnt` increments.
    - When the 4th lane fills, emit the beat.
    - With `rx_last`, emit the partial beat with `last_valid` and the thermometer `keep`, then return to IDLE. Unfilled lanes are 0.
    - If the accepted byte is number `MTU_BYTES` and has no `rx_last`: emit the beat with `last_valid` and `frame_oversize`, then go to DISCARD.
    - If `rx_last` coincides with byte `MTU_BYTES`, the frame ends normally and is not flagged.
  - DISCARD: consume valid bytes silently. The byte with `rx_last` returns the FSM to IDLE and produces no output.
- `byte_cnt` is 11 bits and never wraps, because it is capped by the MTU.
- `rx_valid` low means hold. Gaps inside a frame are allowed without limit.
- `rx_last` with `rx_valid` low is ignored.
- There is no start-of-frame signal. After reset, the first valid byte always starts a frame.

## Timing
- All outputs are registered.
- A beat appears the cycle after the clock edge that accepts its final byte (1-cycle latency).
- `data_valid`, `last_valid`, `frame_runt` and `frame_oversize` are single-cycle pulses.
- `packet4_byte` and `keep` hold their values between beats.
- Back-to-back frames are supported. A byte of frame N+1 may arrive in the cycle after frame N's `rx_last`, and a beat of frame N+1 may follow frame N's last beat with no gap.
- Reset values: all outputs 0, FSM in IDLE, the partial beat cleared.
- Reset asserted mid-frame discards the partial frame and emits nothing.
- An MTU of 1522 gives a truncated last beat with keep 0011 (1522 = 4·380 + 2).

## Configuration
- `BYTE_PACKER_STATS_EN` defined: `stat_frames` counts every emitted last beat. `stat_runts` and `stat_oversize` count their respective flags. All three counters saturate at all-ones and are cleared only by reset.
- Not defined: the counter logic is absent, and the three stat ports remain present but are tied to 0.

## Structure
- Package `byte_packer_pkg`: `MTU_BYTES` and `MIN_HDR_BYTES` defaults, the FSM state enum, and the `keep` thermometer function.
- One sub-module, `byte_packer_stats`: the saturating counters, instantiated only under `BYTE_PACKER_STATS_EN`.

## Test plan
- 64-byte frame 00..3F, contiguous → 16 beats, first beat 0x00010203, last beat 0x3C3D3E3F with keep 1111 and `last_valid`. No flags.
- 61-byte frame → 16th beat keep 0001 with data 0x3C000000. No flags.
- 10-byte frame with random `rx_valid` gaps → 3 beats, last beat keep 0011, `frame_runt`=1. A 1-byte frame → one beat with keep 0001 and `frame_runt`=1.
- 1600-byte frame → 381 beats, last beat keep 0011 with `frame_oversize`. Bytes 1523..1600 produce nothing, and the next frame packs normally. A 1522-byte frame → same beat count with no flag.
- Back-to-back 6-byte frames with no idle cycle → beats 0x..,keep 0011 last for each frame. No lane bleed between frames.
- Reset pulse after 7 bytes → outputs 0. The following 8-byte frame → 2 clean beats. With the stats macro defined, the counters match the flag pulses and read 0 after reset.

Source files
------------

// File: rtl/byte_packer_pkg.sv
// Shared defaults, FSM states and the keep thermometer helper for byte_packer.
package byte_packer_pkg;

    localparam int DEF_MTU_BYTES     = 1522;
    localparam int DEF_MIN_HDR_BYTES = 14;
    localparam int CNT_W             = 11;

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        DISCARD
    } state_e;

    // Thermometer keep code from the lane index that holds the final byte.
    function automatic logic [3:0] keep_therm(input logic [1:0] last_lane);
        case (last_lane)
            2'd0:    keep_therm = 4'b0001;
            2'd1:    keep_therm = 4'b0011;
            2'd2:    keep_therm = 4'b0111;
            default: keep_therm = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/byte_packer_stats.sv
// Saturating frame / runt / oversize counters fed by the registered output pulses.
module byte_packer_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_evt,
    input  logic        runt_evt,
    input  logic        oversize_evt,
    output logic [31:0] stat_frames,
    output logic [15:0] stat_runts,
    output logic [15:0] stat_oversize
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_frames   <= '0;
            stat_runts    <= '0;
            stat_oversize <= '0;
        end else begin
            if (frame_evt && (stat_frames != '1))
                stat_frames <= stat_frames + 32'd1;
            if (runt_evt && (stat_runts != '1))
                stat_runts <= stat_runts + 16'd1;
            if (oversize_evt && (stat_oversize != '1))
                stat_oversize <= stat_oversize + 16'd1;
        end
    end

endmodule

// File: rtl/byte_packer.sv
// Byte-serial to big-endian 32-bit beat packer with MTU truncation and runt flagging.
// Optional statistics counters are built when BYTE_PACKER_STATS_EN is defined.
module byte_packer
    import byte_packer_pkg::*;
#(
    parameter int MTU_BYTES     = DEF_MTU_BYTES,
    parameter int MIN_HDR_BYTES = DEF_MIN_HDR_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        rx_last,
    output logic [31:0] packet4_byte,
    output logic        data_valid,
    output logic        last_valid,
    output logic [3:0]  keep,
    output logic        frame_runt,
    output logic        frame_oversize,
    output logic [31:0] stat_frames,
    output logic [15:0] stat_runts,
    output logic [15:0] stat_oversize
);

    localparam logic [CNT_W-1:0] MTU_CNT = CNT_W'(MTU_BYTES);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_HDR_BYTES);

    state_e           state;
    logic [CNT_W-1:0] byte_cnt;   // held at 0 outside PACK so IDLE shares the PACK datapath
    logic [31:0]      acc;

    logic [1:0]       lane;
    logic [CNT_W-1:0] cnt_next;
    logic [31:0]      beat;
    logic             at_mtu;
    logic             emit;

    always_comb begin
        // NOTE: every combinational output is given a default first so no latch is inferred.
        lane     = byte_cnt[1:0];
        cnt_next = byte_cnt + CNT_W'(1);
        beat     = acc | ({rx_byte, 24'h0} >> {lane, 3'b000});
        at_mtu   = (cnt_next == MTU_CNT);
        emit     = (lane == 2'd3) || rx_last || at_mtu;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            byte_cnt       <= '0;
            // NOTE: the partial beat is reset too, since unfilled lanes are ORed into the next beat.
            acc            <= '0;
            packet4_byte   <= '0;
            keep           <= '0;
            data_valid     <= 1'b0;
            last_valid     <= 1'b0;
            frame_runt     <= 1'b0;
            frame_oversize <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            data_valid     <= 1'b0;
            last_valid     <= 1'b0;
            frame_runt     <= 1'b0;
            frame_oversize <= 1'b0;
            if (rx_valid) begin
                case (state)
                    IDLE, PACK: begin
                        if (emit) begin
                            packet4_byte   <= beat;
                            keep           <= keep_therm(lane);
                            data_valid     <= 1'b1;
                            last_valid     <= rx_last || at_mtu;
                            frame_runt     <= rx_last && (cnt_next < MIN_CNT);
                            frame_oversize <= at_mtu && !rx_last;
                            acc            <= '0;
                        end else begin
                            acc <= beat;
                        end
                        if (rx_last) begin
                            state    <= IDLE;
                            byte_cnt <= '0;
                        end else if (at_mtu) begin
                            state    <= DISCARD;
                            byte_cnt <= '0;
                        end else begin
                            state    <= PACK;
                            byte_cnt <= cnt_next;
                        end
                    end
                    DISCARD: begin
                        if (rx_last)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef BYTE_PACKER_STATS_EN
    byte_packer_stats u_stats (
        .clk          (clk),
        .rst          (rst),
        .frame_evt    (data_valid && last_valid),
        .runt_evt     (frame_runt),
        .oversize_evt (frame_oversize),
        .stat_frames  (stat_frames),
        .stat_runts   (stat_runts),
        .stat_oversize(stat_oversize)
    );
`else
    assign stat_frames   = '0;
    assign stat_runts    = '0;
    assign stat_oversize = '0;
`endif

endmodule

// File: tb/tb_byte_packer.sv
// Randomized self-checking bench for byte_packer: a frame-level model predicts every cycle's outputs.
module tb_byte_packer;

    localparam int MTU     = 1522;
    localparam int MIN_HDR = 14;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        valid;
        logic        last;
        logic        runt;
        logic        over;
        int          sf;
        int          sr;
        int          so;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        r;
        logic        o;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        rx_valid = 1'b0;
    logic        rx_last = 1'b0;
    logic [31:0] packet4_byte;
    logic        data_valid;
    logic        last_valid;
    logic [3:0]  keep;
    logic        frame_runt;
    logic        frame_oversize;
    logic [31:0] stat_frames;
    logic [15:0] stat_runts;
    logic [15:0] stat_oversize;

    int total = 0;
    int bad   = 0;

    exp_t  nxt = '{default: '0};
    exp_t  cur = '{default: '0};
    exp_t  mdl_last = '{default: '0};
    beat_t dut_beats[$];

    logic [7:0] frame_q[$];
    int  frame_len = 0;
    bit  in_frame = 1'b0;
    int  st_f = 0, st_r = 0, st_o = 0;

    byte_packer dut (
        .clk           (clk),
        .rst           (rst),
        .rx_byte       (rx_byte),
        .rx_valid      (rx_valid),
        .rx_last       (rx_last),
        .packet4_byte  (packet4_byte),
        .data_valid    (data_valid),
        .last_valid    (last_valid),
        .keep          (keep),
        .frame_runt    (frame_runt),
        .frame_oversize(frame_oversize),
        .stat_frames   (stat_frames),
        .stat_runts    (stat_runts),
        .stat_oversize (stat_oversize)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a beat closes on every 4th byte, on the last byte, or at the MTU byte.
    task automatic model_accept(input logic [7:0] b, input bit l);
        int n;
        logic [31:0] d;
        if (!in_frame) begin
            in_frame  = 1'b1;
            frame_len = 0;
            frame_q.delete();
        end
        frame_len++;
        if (frame_len <= MTU) begin
            frame_q.push_back(b);
            if ((frame_len % 4 == 0) || l || (frame_len == MTU)) begin
                n = (frame_len - 1) % 4 + 1;
                d = '0;
                for (int k = 0; k < n; k++)
                    d[31 - 8*k -: 8] = frame_q[frame_len - n + k];
                nxt.data  = d;
                nxt.keep  = 4'((1 << n) - 1);
                nxt.valid = 1'b1;
                nxt.last  = l || (frame_len == MTU);
                nxt.runt  = l && (frame_len < MIN_HDR);
                nxt.over  = !l && (frame_len == MTU);
                mdl_last  = nxt;
            end
        end
        if (l) in_frame = 1'b0;
    endtask

    task automatic drive(input bit r, input bit v, input logic [7:0] b, input bit l);
        @(negedge clk);
        // Pulses visible now are counted by the stats block at the coming edge.
        st_f += (nxt.valid && nxt.last) ? 1 : 0;
        st_r += nxt.runt ? 1 : 0;
        st_o += nxt.over ? 1 : 0;
        nxt.valid = 1'b0;
        nxt.last  = 1'b0;
        nxt.runt  = 1'b0;
        nxt.over  = 1'b0;
        rst      = r;
        rx_valid = v;
        rx_byte  = b;
        rx_last  = l;
        if (!r) begin
            in_frame = 1'b0;
            nxt.data = '0;
            nxt.keep = '0;
            st_f = 0;
            st_r = 0;
            st_o = 0;
        end else if (v) begin
            model_accept(b, l);
        end
        nxt.sf = st_f;
        nxt.sr = st_r;
        nxt.so = st_o;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b1, 1'b0, 8'($urandom), 1'($urandom));
    endtask

    task automatic send_frame(input int len, input int gap_pct, input bit incr, input logic [7:0] base);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct)
                drive(1'b1, 1'b0, 8'($urandom), 1'($urandom));
            b = incr ? 8'(base + i) : 8'($urandom);
            drive(1'b1, 1'b1, b, i == len - 1);
        end
    endtask

    // Per-cycle comparison of every output against the model's prediction for this edge.
    always @(posedge clk) begin
        cur = nxt;
        #2;
        check("packet4_byte", packet4_byte, cur.data);
        check("keep", {28'b0, keep}, {28'b0, cur.keep});
        check("pulses(dv,lv,runt,over)",
              {28'b0, data_valid, last_valid, frame_runt, frame_oversize},
              {28'b0, cur.valid, cur.last, cur.runt, cur.over});
`ifdef BYTE_PACKER_STATS_EN
        check("stat_frames", stat_frames, 32'(cur.sf));
        check("stat_runts", {16'b0, stat_runts}, 32'(cur.sr));
        check("stat_oversize", {16'b0, stat_oversize}, 32'(cur.so));
`else
        check("stat_ports_tied", stat_frames | {16'b0, stat_runts} | {16'b0, stat_oversize}, 32'h0);
`endif
        if (data_valid)
            dut_beats.push_back('{packet4_byte, keep, last_valid, frame_runt, frame_oversize});
    end

    function automatic logic [31:0] last_flags();
        beat_t t;
        t = dut_beats[$];
        return {25'b0, t.k, t.l, t.r, t.o};
    endfunction

    initial begin
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("reset_data", packet4_byte, 32'h0);
        check("reset_pulses", {28'b0, data_valid, last_valid, frame_runt, frame_oversize}, 32'h0);
        idle(2);

        // 64-byte contiguous frame
        dut_beats.delete();
        send_frame(64, 0, 1'b1, 8'h00);
        idle(2);
        check("f64_beats", 32'(dut_beats.size()), 32'd16);
        check("f64_first", dut_beats[0].d, 32'h00010203);
        check("f64_last", dut_beats[$].d, 32'h3C3D3E3F);
        check("f64_flags", last_flags(), {25'b0, 4'b1111, 3'b100});

        // 61-byte frame
        dut_beats.delete();
        send_frame(61, 0, 1'b1, 8'h00);
        idle(2);
        check("model_f61_last", mdl_last.data, 32'h3C000000);
        check("f61_beats", 32'(dut_beats.size()), 32'd16);
        check("f61_last", dut_beats[$].d, 32'h3C000000);
        check("f61_flags", last_flags(), {25'b0, 4'b0001, 3'b100});

        // 10-byte runt with gaps, then a 1-byte frame
        dut_beats.delete();
        send_frame(10, 40, 1'b0, 8'h00);
        idle(2);
        check("f10_beats", 32'(dut_beats.size()), 32'd3);
        check("f10_flags", last_flags(), {25'b0, 4'b0011, 3'b110});
        dut_beats.delete();
        send_frame(1, 0, 1'b1, 8'h5A);
        idle(2);
        check("f1_beats", 32'(dut_beats.size()), 32'd1);
        check("f1_data", dut_beats[$].d, 32'h5A000000);
        check("f1_flags", last_flags(), {25'b0, 4'b0001, 3'b110});

        // Oversize 1600 then normal frame; exact-MTU frame
        dut_beats.delete();
        send_frame(1600, 0, 1'b1, 8'h00);
        idle(2);
        check("f1600_beats", 32'(dut_beats.size()), 32'd381);
        check("f1600_last", dut_beats[$].d, 32'hF0F10000);
        check("f1600_flags", last_flags(), {25'b0, 4'b0011, 3'b101});
        dut_beats.delete();
        send_frame(8, 0, 1'b1, 8'h20);
        idle(2);
        check("after_over_beats", 32'(dut_beats.size()), 32'd2);
        check("after_over_first", dut_beats[0].d, 32'h20212223);
        dut_beats.delete();
        send_frame(1522, 0, 1'b1, 8'h00);
        idle(2);
        check("f1522_beats", 32'(dut_beats.size()), 32'd381);
        check("f1522_flags", last_flags(), {25'b0, 4'b0011, 3'b100});

        // Back-to-back 6-byte frames
        dut_beats.delete();
        send_frame(6, 0, 1'b1, 8'hA0);
        send_frame(6, 0, 1'b1, 8'hB0);
        send_frame(6, 0, 1'b1, 8'hC0);
        idle(2);
        check("b2b_beats", 32'(dut_beats.size()), 32'd6);
        check("b2b_tail_a", dut_beats[1].d, 32'hA4A50000);
        check("b2b_head_b", dut_beats[2].d, 32'hB0B1B2B3);
        check("b2b_tail_c", {dut_beats[5].d[31:0]}, 32'hC4C50000);

        // Reset mid-frame after 7 bytes
        dut_beats.delete();
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 8'(8'h70 + i), 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("midreset_data", packet4_byte, 32'h0);
        check("midreset_stats", stat_frames, 32'h0);
        dut_beats.delete();
        send_frame(8, 0, 1'b1, 8'h10);
        idle(2);
        check("post_reset_beats", 32'(dut_beats.size()), 32'd2);
        check("post_reset_b0", dut_beats[0].d, 32'h10111213);
        check("post_reset_b1", dut_beats[1].d, 32'h14151617);

        // Randomized traffic, including frames around the MTU
        for (int f = 0; f < 150; f++)
            send_frame($urandom_range(70, 1), $urandom_range(50), 1'b0, 8'h00);
        for (int f = 0; f < 2; f++)
            send_frame($urandom_range(1540, 1515), $urandom_range(20), 1'b0, 8'h00);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
